polyphase_fir_mac: RTL

Polyphase FIR multiply-accumulate stage sitting directly downstream of the input-buffer address processor in the I=3/D=4 resampler. Consumes samples read from input-buffer port B and the current phase select FirInSel. Runs TAPS MAC cycles per output sample against a coefficient ROM, then rounds, saturates and writes one result to the output buffer. Its OutBufwea pulse is the advance strobe fed back to the upstream FIR address generator.

---
 rtl/polyphase_fir_mac.sv | 104 ++++++++++
 1 files changed

// File: rtl/polyphase_fir_mac.sv
// Polyphase FIR MAC stage: TAPS multiply-accumulates per output against a phase-indexed
// coefficient ROM, then round/saturate and one output-buffer write that doubles as the upstream advance strobe.
module polyphase_fir_mac #(
   parameter int TAPS  = 21,
   parameter int I     = 3,
   parameter int NOUT  = 576,
   parameter int DW    = 16,
   parameter int ACC_W = 40,
   parameter int SHIFT = 15
) (
   input  logic          sys_clk,
   input  logic          reset,
   input  logic          FirStart,
   input  logic [1:0]    FirInSel,
   input  logic [DW-1:0] InBufDoutb,
   output logic [5:0]    CoefAddr,
   input  logic [DW-1:0] CoefDout,
   output logic [9:0]    OutBufAddra,
   output logic [DW-1:0] OutBufDina,
   output logic          OutBufwea,
   output logic          FirBusy,
   output logic          FirDone
);
   typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;
   localparam int STAGES = 1;
   localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(2**(SHIFT-1));
   localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(DW-1)-1);
   localparam logic signed [ACC_W:0] MINV = -MAXV - 1;

   state_t                  state;
   logic [4:0]              tap;
   logic [1:0]              phase, sel_eff, ph_c;
   logic [STAGES:0]         vld_pipe, first_pipe;
   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] acc;
   logic [9:0]              addr;
   logic signed [ACC_W:0]   rsum, rsh;
   logic [DW-1:0]           rsat;

   // Out-of-range phase selects fold to phase 0; on tap 0 the live select is used directly.
   assign sel_eff     = (FirInSel < 2'(I)) ? FirInSel : 2'd0;
   assign ph_c        = (tap == 5'd0) ? sel_eff : phase;
   assign CoefAddr    = (state == MAC) ? 6'(ph_c) * 6'(TAPS) + 6'(tap) : 6'd0;
   assign OutBufAddra = addr;
   assign FirBusy     = (state == MAC) || (state == DRAIN) || (state == WRITE);
   assign FirDone     = (state == DONE);

   always_comb begin
      rsum = (ACC_W+1)'(acc) + HALF;
      rsh  = rsum >>> SHIFT;
      if (rsh > MAXV)      rsat = MAXV[DW-1:0];
      else if (rsh < MINV) rsat = MINV[DW-1:0];
      else                 rsat = rsh[DW-1:0];
   end

   always_ff @(posedge sys_clk) begin
      if (!reset) begin
         state      <= IDLE;
         tap        <= '0;
         phase      <= '0;
         vld_pipe   <= '0;
         first_pipe <= '0;
         prod       <= '0;
         acc        <= '0;
         addr       <= '0;
         OutBufDina <= '0;
         OutBufwea  <= 1'b0;
      end else begin
         // vld_pipe[0]: operands on the read ports; vld_pipe[1]: product registered
         vld_pipe   <= {vld_pipe[STAGES-1:0], state == MAC};
         first_pipe <= {first_pipe[STAGES-1:0], tap == 5'd0};
         if (vld_pipe[0]) prod <= $signed(InBufDoutb) * $signed(CoefDout);
         if (vld_pipe[1]) acc  <= first_pipe[1] ? ACC_W'(prod) : acc + ACC_W'(prod);
         OutBufwea <= 1'b0;
         case (state)
            IDLE: if (FirStart) begin
               state <= MAC;
               addr  <= '0;
               tap   <= '0;
            end
            MAC: begin
               if (tap == 5'd0) phase <= sel_eff;
               if (tap == 5'(TAPS-1)) begin
                  tap   <= '0;
                  state <= DRAIN;
               end else tap <= tap + 5'd1;
            end
            DRAIN: if (tap == 5'd2) begin
               tap        <= '0;
               state      <= WRITE;
               OutBufwea  <= 1'b1;
               OutBufDina <= rsat;
            end else tap <= tap + 5'd1;
            WRITE: if (addr == 10'(NOUT-1)) state <= DONE;
               else begin
                  addr  <= addr + 10'd1;
                  state <= MAC;
               end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
